i2c_pad_conditioner: RTL and testbench
======================================

# i2c_pad_conditioner

Pad-side stage between the `i2c_master` open-drain pins (`scl_o/scl_t/sda_o/sda_t/scl_i/sda_i`) and the TinyQV IO pads. It performs the following functions:
- Synchronises and glitch-filters incoming SCL/SDA before the master sees them.
- Converts the master's drive into pad output-enables.
- Provides a firmware-triggered bus-recovery sequence: up to 9 SCL pulses plus STOP, used when a slave holds SDA low.
- Optionally detects SCL stuck low.

## Interface
Parameters:
- `SYNC_STAGES`, 2: input synchroniser depth (≥2).
- `FILTER_LEN`, 3: consecutive post-sync cycles a new level must hold before it is accepted (≥1).
- `TIMEOUT_CYCLES`, 625000: SCL-low cycles before `stuck_low` asserts (25 ms at 25 MHz).

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: synchronous, active-low reset.
- `scl_o_core`, `scl_t_core`, `sda_o_core`, `sda_t_core` in 1 each: master drive. A line is pulled low when its `_t` is 0.
- `scl_i_core`, `sda_i_core` out 1 each: filtered line levels to the master.
- `scl_pad_i`, `sda_pad_i` in 1 each: raw pad levels.
- `scl_pad_oe`, `sda_pad_oe` out 1 each: 1 = drive pad low. The pad output data is tied 0.
- `core_busy` in 1: master `busy`.
- `prescale` in 16: same value as the I2C_CONFIG prescale. One quarter bit-period equals `prescale` cycles.
- `recover_req` in 1: single-cycle request to start recovery.
- `recover_busy` out 1: recovery in progress.
- `recover_done` out 1: one-cycle pulse when recovery ends.
- `recover_fail` out 1: sticky flag. Set when SDA is still low at the end of recovery; cleared by the next accepted `recover_req`.
- `stuck_low` out 1: SCL held low ≥ `TIMEOUT_CYCLES`.

## Operation
- **Filter (per line):**
  - `sync` is the last synchroniser stage.
  - The counter increments while `sync != filt` and clears when they are equal.
  - When the counter reaches `FILTER_LEN-1` and `sync` still differs, `filt <= sync` and the counter clears.
  - `scl_i_core`/`sda_i_core` = `filt`.
- **Drive, when not recovering:** `scl_pad_oe = !scl_t_core`, `sda_pad_oe = !sda_t_core`. This path is combinational.
- **Drive, during recovery:** core drive is ignored. The pads are driven from FSM registers.
- **Recovery FSM states:** IDLE, PULSE_LOW, PULSE_HIGH, STOP_SETUP, STOP_SCL, STOP_SDA, DONE.
  - **IDLE:** `recover_req && !core_busy` → PULSE_LOW, with pulse count = 0. Otherwise the request is ignored (no status change).
  - **PULSE_LOW:** drive SCL low for H = 2·max(`prescale`,1) cycles → PULSE_HIGH.
  - **PULSE_HIGH:** release SCL. The timer counts only while filtered SCL = 1 (clock-stretch tolerant). After H counted cycles, the pulse count increments, then:
    - If filtered SDA = 1 or count = 9 → STOP_SETUP.
    - Otherwise → PULSE_LOW.
  - **STOP_SETUP:** drive SCL and SDA low for H cycles → STOP_SCL.
  - **STOP_SCL:** release SCL and hold SDA low for H counted-high cycles → STOP_SDA.
  - **STOP_SDA:** release SDA and wait H cycles → DONE.
  - **DONE:** one cycle. `recover_done = 1`, `recover_fail <= !filt_sda` → IDLE.
- **Stuck detector:**
  - A saturating counter increments while filtered SCL = 0 and clears when SCL = 1.
  - `stuck_low = (count >= TIMEOUT_CYCLES)`.
  - It is active in all FSM states.

## Timing
- **Reset values:** `scl_pad_oe` = `sda_pad_oe` = 0 (released); `scl_i_core` = `sda_i_core` = 1; all synchroniser stages = 1; `recover_busy` = `recover_done` = `recover_fail` = `stuck_low` = 0; FSM = IDLE.
- **Pad→core latency:** a step on a pad that holds appears at the core output `SYNC_STAGES + FILTER_LEN` cycles later. A pulse shorter than `FILTER_LEN` post-sync cycles never appears.
- **Core→pad latency:** 0 cycles outside recovery.
- **`recover_busy`:** high from the cycle after an accepted `recover_req` through DONE inclusive.
- **Recovery takes effect one cycle after acceptance.** The first SCL-low edge occurs in that cycle.
- **`recover_req` while busy:** ignored.
- **`core_busy` rising during recovery:** ignored. Firmware guarantees the master is idle.
- **Reset asserted mid-recovery:** next edge returns to IDLE, both pads released, no `recover_done`.
- **`prescale` change mid-recovery:** takes effect at the next phase start. The current timer is not reloaded.

## Configuration
- `I2C_PAD_TIMEOUT_EN` defined: stuck-low counter (⌈log2(TIMEOUT_CYCLES+1)⌉ bits) compiled in.
- `I2C_PAD_TIMEOUT_EN` undefined: no counter; `stuck_low` tied 0.

## Structure
- **Package `i2c_pad_pkg`:** recovery state enum, `RECOVERY_PULSES = 9`, default `TIMEOUT_CYCLES`.
- **Sub-module `i2c_line_filter`:** synchroniser plus filter, parameterised by `SYNC_STAGES`/`FILTER_LEN`, instantiated once for SCL and once for SDA.
- **Top level:** drive mux, recovery FSM, phase timer, stuck detector.

## Test plan
- **Reset:** assert `rst_n` = 0 for 2 cycles → both `_oe` = 0, `scl_i_core` = `sda_i_core` = 1, all status outputs = 0.
- **Glitch filter:** 2-cycle low glitch on `sda_pad_i` → `sda_i_core` stays 1. A 3-cycle low step → `sda_i_core` = 0 exactly 5 cycles after the step, with default parameters.
- **Recovery, SDA stuck low:** `prescale` = 4, `sda_pad_i` held 0 → exactly 9 SCL low pulses of 8 cycles each, then STOP attempt. `recover_done` pulses once; `recover_fail` = 1.
- **Recovery, early release:** the slave releases SDA after the 3rd pulse → STOP follows the 3rd pulse, total 3 pulses; `recover_fail` = 0.
- **Clock stretch and request gating:**
  - Slave holds SCL low 20 cycles in PULSE_HIGH → that high phase is extended by 20 cycles.
  - `recover_req` with `core_busy` = 1 → ignored; `recover_busy` stays 0.
- **Stuck timeout:** `TIMEOUT_CYCLES` = 100, `I2C_PAD_TIMEOUT_EN` defined, SCL pad held 0 → `stuck_low` = 1 at cycle 100 after the filtered fall; it clears 1 cycle after the filtered rise.

Source files
------------

// File: rtl/i2c_pad_pkg.sv
// Shared types and constants for the I2C pad conditioner: recovery FSM states,
// recovery pulse limit, default stuck-low timeout and the half-period helper.
package i2c_pad_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PULSE_LOW,
      ST_PULSE_HIGH,
      ST_STOP_SETUP,
      ST_STOP_SCL,
      ST_STOP_SDA,
      ST_DONE
   } rec_state_t;

   localparam int RECOVERY_PULSES        = 9;
   localparam int DEFAULT_TIMEOUT_CYCLES = 625000;

   // Half SCL period in clk cycles: two quarter periods, prescale of 0 treated as 1.
   function automatic logic [16:0] half_period_cycles(input logic [15:0] prescale);
      return (prescale == 16'd0) ? 17'd2 : {prescale, 1'b0};
   endfunction

endpackage

// File: rtl/i2c_pad_conditioner_filter.sv
// Per-line input conditioning: SYNC_STAGES-deep synchroniser followed by a
// level filter that accepts a new level only after FILTER_LEN steady cycles.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILTER_LEN  = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pad,
   output logic filt
);

   localparam int CNT_W = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   sync;
   logic [CNT_W-1:0]       cnt_reg;
   logic                   filt_reg;

   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (!rst_n) sync_reg[gi] <= 1'b1;
               else        sync_reg[gi] <= pad;
            end
         end else begin : g_chain
            always_ff @(posedge clk) begin
               if (!rst_n) sync_reg[gi] <= 1'b1;
               else        sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign sync = sync_reg[SYNC_STAGES-1];

   // The counter restarts on any return to the accepted level, so short pulses never pass.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_reg  <= '0;
         filt_reg <= 1'b1;
      end else if (sync == filt_reg) begin
         cnt_reg <= '0;
      end else if (cnt_reg == CNT_W'(FILTER_LEN - 1)) begin
         filt_reg <= sync;
         cnt_reg  <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign filt = filt_reg;

endmodule

// File: rtl/i2c_pad_conditioner.sv
// Pad-side stage for the I2C master: input filtering, open-drain drive mux and
// bus-recovery FSM. Define I2C_PAD_TIMEOUT_EN to build the SCL stuck-low detector.
module i2c_pad_conditioner
   import i2c_pad_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 3,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_o_core,
   input  logic        scl_t_core,
   input  logic        sda_o_core,
   input  logic        sda_t_core,
   output logic        scl_i_core,
   output logic        sda_i_core,
   input  logic        scl_pad_i,
   input  logic        sda_pad_i,
   output logic        scl_pad_oe,
   output logic        sda_pad_oe,
   input  logic        core_busy,
   input  logic [15:0] prescale,
   input  logic        recover_req,
   output logic        recover_busy,
   output logic        recover_done,
   output logic        recover_fail,
   output logic        stuck_low
);

   logic filt_scl;
   logic filt_sda;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_scl_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (scl_pad_i),
      .filt  (filt_scl)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_sda_filter (
      .clk   (clk),
      .rst_n (rst_n),
      .pad   (sda_pad_i),
      .filt  (filt_sda)
   );

   assign scl_i_core = filt_scl;
   assign sda_i_core = filt_sda;

   // Pad data is tied low, so the core's _o values carry no information here.
   logic unused_core_data;
   assign unused_core_data = &{1'b0, scl_o_core, sda_o_core};

   rec_state_t  state_reg, state_next;
   logic [16:0] timer_reg, timer_next;
   logic [3:0]  pulse_cnt_reg, pulse_cnt_next;
   logic        scl_drv_reg, scl_drv_next;
   logic        sda_drv_reg, sda_drv_next;
   logic        fail_reg, fail_next;
   logic [16:0] load_value;
   logic        timer_zero;
   logic [3:0]  pulse_inc;

   // Prescale is sampled only when a phase starts; a running timer keeps its value.
   assign load_value = half_period_cycles(prescale) - 17'd1;
   assign timer_zero = (timer_reg == 17'd0);
   assign pulse_inc  = pulse_cnt_reg + 4'd1;

   always_comb begin
      state_next     = state_reg;
      timer_next     = timer_reg;
      pulse_cnt_next = pulse_cnt_reg;
      scl_drv_next   = scl_drv_reg;
      sda_drv_next   = sda_drv_reg;
      fail_next      = fail_reg;
      case (state_reg)
         ST_IDLE: begin
            scl_drv_next = 1'b0;
            sda_drv_next = 1'b0;
            if (recover_req && !core_busy) begin
               state_next     = ST_PULSE_LOW;
               timer_next     = load_value;
               pulse_cnt_next = 4'd0;
               scl_drv_next   = 1'b1;
               fail_next      = 1'b0;
            end
         end
         ST_PULSE_LOW: begin
            if (timer_zero) begin
               state_next   = ST_PULSE_HIGH;
               timer_next   = load_value;
               scl_drv_next = 1'b0;
            end else begin
               timer_next = timer_reg - 17'd1;
            end
         end
         ST_PULSE_HIGH: begin
            // Only cycles where SCL is seen high count, so a stretching slave extends the phase.
            if (filt_scl) begin
               if (timer_zero) begin
                  pulse_cnt_next = pulse_inc;
                  timer_next     = load_value;
                  scl_drv_next   = 1'b1;
                  if (filt_sda || pulse_inc == 4'(RECOVERY_PULSES)) begin
                     state_next   = ST_STOP_SETUP;
                     sda_drv_next = 1'b1;
                  end else begin
                     state_next = ST_PULSE_LOW;
                  end
               end else begin
                  timer_next = timer_reg - 17'd1;
               end
            end
         end
         ST_STOP_SETUP: begin
            if (timer_zero) begin
               state_next   = ST_STOP_SCL;
               timer_next   = load_value;
               scl_drv_next = 1'b0;
            end else begin
               timer_next = timer_reg - 17'd1;
            end
         end
         ST_STOP_SCL: begin
            if (filt_scl) begin
               if (timer_zero) begin
                  state_next   = ST_STOP_SDA;
                  timer_next   = load_value;
                  sda_drv_next = 1'b0;
               end else begin
                  timer_next = timer_reg - 17'd1;
               end
            end
         end
         ST_STOP_SDA: begin
            if (timer_zero) state_next = ST_DONE;
            else            timer_next = timer_reg - 17'd1;
         end
         ST_DONE: begin
            state_next = ST_IDLE;
            fail_next  = !filt_sda;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ST_IDLE;
         timer_reg     <= '0;
         pulse_cnt_reg <= '0;
         scl_drv_reg   <= 1'b0;
         sda_drv_reg   <= 1'b0;
         fail_reg      <= 1'b0;
      end else begin
         state_reg     <= state_next;
         timer_reg     <= timer_next;
         pulse_cnt_reg <= pulse_cnt_next;
         scl_drv_reg   <= scl_drv_next;
         sda_drv_reg   <= sda_drv_next;
         fail_reg      <= fail_next;
      end
   end

   assign recover_busy = (state_reg != ST_IDLE);
   assign recover_done = (state_reg == ST_DONE);
   assign recover_fail = fail_reg;
   assign scl_pad_oe   = recover_busy ? scl_drv_reg : !scl_t_core;
   assign sda_pad_oe   = recover_busy ? sda_drv_reg : !sda_t_core;

`ifdef I2C_PAD_TIMEOUT_EN
   localparam int STUCK_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [STUCK_W-1:0] stuck_cnt_reg;

   always_ff @(posedge clk) begin
      if (!rst_n || filt_scl) begin
         stuck_cnt_reg <= '0;
      end else if (stuck_cnt_reg < STUCK_W'(TIMEOUT_CYCLES)) begin
         stuck_cnt_reg <= stuck_cnt_reg + 1'b1;
      end
   end

   assign stuck_low = (stuck_cnt_reg >= STUCK_W'(TIMEOUT_CYCLES));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES == 0);
   assign stuck_low      = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_pad_conditioner.sv
// Self-checking bench for i2c_pad_conditioner: open-drain pad model with a
// scripted slave, plus a scoreboard of expected recovery outcomes.
module tb_i2c_pad_conditioner;

   localparam int SYNC_STAGES = 2;
   localparam int FILTER_LEN  = 3;
   localparam int PAD_LAT     = SYNC_STAGES + FILTER_LEN;
`ifdef I2C_PAD_TIMEOUT_EN
   localparam int EXP_STUCK_LAT = 100;
   localparam int EXP_STUCK_HI  = 1;
`else
   localparam int EXP_STUCK_LAT = 0;
   localparam int EXP_STUCK_HI  = 0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scl_o_core = 1'b0, scl_t_core = 1'b1;
   logic        sda_o_core = 1'b0, sda_t_core = 1'b1;
   logic        scl_i_core, sda_i_core;
   logic        scl_pad_i, sda_pad_i;
   logic        scl_pad_oe, sda_pad_oe;
   logic        core_busy = 1'b0;
   logic [15:0] prescale = 16'd4;
   logic        recover_req = 1'b0;
   logic        recover_busy, recover_done, recover_fail, stuck_low;

   // Slave / environment controls (written by the stimulus process)
   logic glitch_low = 1'b0;
   logic scl_force_low = 1'b0;
   logic slave_sda_low = 1'b0;
   int   sda_release_after = 99;
   int   stretch_idx = -1;
   // Written by the monitor only
   logic slave_released = 1'b0;
   logic scl_hold = 1'b0;

   assign scl_pad_i = !scl_pad_oe && !scl_hold && !scl_force_low;
   assign sda_pad_i = !sda_pad_oe && !(slave_sda_low && !slave_released) && !glitch_low;

   always #5 clk = ~clk;

   i2c_pad_conditioner #(
      .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(100)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .scl_o_core(scl_o_core), .scl_t_core(scl_t_core),
      .sda_o_core(sda_o_core), .sda_t_core(sda_t_core),
      .scl_i_core(scl_i_core), .sda_i_core(sda_i_core),
      .scl_pad_i(scl_pad_i), .sda_pad_i(sda_pad_i),
      .scl_pad_oe(scl_pad_oe), .sda_pad_oe(sda_pad_oe),
      .core_busy(core_busy), .prescale(prescale),
      .recover_req(recover_req), .recover_busy(recover_busy),
      .recover_done(recover_done), .recover_fail(recover_fail),
      .stuck_low(stuck_low)
   );

   typedef struct {
      int pulses;
      int fail;
      int stretch;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check_val(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- monitor ----------------
   logic busy_prev = 1'b0, oe_prev = 1'b0, clk_pulse = 1'b0;
   int   pulses_seen = 0, lo_cnt = 0, hi_cnt = 0, hi_idx = 0;
   int   lo_err = 0, hi_err = 0, stretch_left = 0;
   int   h_exp, exp_w;
   logic fail_pending = 1'b0;
   int   fail_exp = 0;
   exp_t e_cur;

   always @(negedge clk) begin
      h_exp = 2 * ((prescale == 16'd0) ? 1 : int'(prescale));
      if (fail_pending) begin
         check_val("recover_fail", int'(recover_fail), fail_exp);
         fail_pending = 1'b0;
      end
      if (recover_busy && !busy_prev) begin
         pulses_seen = 0; lo_err = 0; hi_err = 0; hi_cnt = 0;
         slave_released = 1'b0; scl_hold = 1'b0;
      end
      if (scl_hold) begin
         stretch_left--;
         if (stretch_left == 0) scl_hold = 1'b0;
      end
      if (recover_busy) begin
         if (scl_pad_oe && !oe_prev) begin
            if (hi_cnt > 0) begin
               exp_w = PAD_LAT + h_exp + ((hi_idx == stretch_idx) ? 20 : 0);
               if (hi_cnt != exp_w) hi_err++;
            end
            hi_cnt    = 0;
            clk_pulse = !sda_pad_oe;
            if (clk_pulse) pulses_seen++;
            lo_cnt = 1;
         end else if (scl_pad_oe) begin
            lo_cnt++;
         end else if (oe_prev) begin
            if (clk_pulse) begin
               if (lo_cnt != h_exp) lo_err++;
               hi_cnt = 1;
               hi_idx = pulses_seen;
               if (stretch_idx == pulses_seen) begin
                  scl_hold = 1'b1;
                  stretch_left = 20;
               end
            end
         end else if (hi_cnt > 0) begin
            hi_cnt++;
         end
         if (!slave_released && pulses_seen >= sda_release_after && !scl_pad_oe)
            slave_released = 1'b1;
      end
      if (recover_done) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_done", 1, 0);
         end else begin
            e_cur = sb_q.pop_front();
            $display("recovery done: pulses=%0d low_width_err=%0d high_width_err=%0d",
                     pulses_seen, lo_err, hi_err);
            check_val("pulse_count", pulses_seen, e_cur.pulses);
            check_val("low_width", lo_err, 0);
            check_val("high_width", hi_err, 0);
            check_val("busy_in_done", int'(recover_busy), 1);
            fail_exp     = e_cur.fail;
            fail_pending = 1'b1;
         end
      end
      busy_prev = recover_busy;
      oe_prev   = scl_pad_oe;
   end

   // ---------------- stimulus ----------------
   task automatic start_recovery(input int pulses, input int fail, input int stretch);
      sb_q.push_back('{pulses, fail, stretch});
      stretch_idx = stretch;
      recover_req = 1'b1;
      check_val("busy_before_accept", int'(recover_busy), 0);
      tick();
      recover_req = 1'b0;
      check_val("busy_after_accept", int'(recover_busy), 1);
      check_val("scl_low_first_cycle", int'(scl_pad_oe), 1);
      check_val("fail_cleared", int'(recover_fail), 0);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while (recover_busy && n < budget) begin
         tick();
         n++;
      end
      if (recover_busy) check_val("idle_timeout", 1, 0);
   endtask

   initial begin
      int lat;
      int seen_low;
      int n;

      // Reset
      rst_n = 1'b0;
      tick(); tick();
      check_val("rst_scl_oe", int'(scl_pad_oe), 0);
      check_val("rst_sda_oe", int'(sda_pad_oe), 0);
      check_val("rst_scl_i", int'(scl_i_core), 1);
      check_val("rst_sda_i", int'(sda_i_core), 1);
      check_val("rst_status", int'({recover_busy, recover_done, recover_fail, stuck_low}), 0);
      rst_n = 1'b1;
      tick();

      // Core drive is combinational outside recovery
      scl_t_core = 1'b0; #1;
      check_val("scl_oe_passthru", int'(scl_pad_oe), 1);
      scl_t_core = 1'b1; sda_t_core = 1'b0; #1;
      check_val("sda_oe_passthru", int'(sda_pad_oe), 1);
      check_val("scl_oe_released", int'(scl_pad_oe), 0);
      sda_t_core = 1'b1;
      repeat (10) tick();

      // Glitch rejection and step latency on SDA
      glitch_low = 1'b1; tick(); tick(); glitch_low = 1'b0;
      seen_low = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (!sda_i_core) seen_low = 1;
      end
      check_val("glitch_reject", seen_low, 0);
      glitch_low = 1'b1; lat = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (!sda_i_core && lat == 0) lat = i;
      end
      check_val("sda_fall_latency", lat, PAD_LAT);
      glitch_low = 1'b0; lat = 0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (sda_i_core && lat == 0) lat = i;
      end
      check_val("sda_rise_latency", lat, PAD_LAT);

      // Stuck-low detector
      scl_force_low = 1'b1; n = 0;
      while (scl_i_core && n < 20) begin tick(); n++; end
      check_val("scl_fall_latency", n, PAD_LAT);
      lat = 0;
      for (int i = 1; i <= 150; i++) begin
         tick();
         if (stuck_low && lat == 0) lat = i;
      end
      check_val("stuck_latency", lat, EXP_STUCK_LAT);
      scl_force_low = 1'b0; n = 0;
      while (!scl_i_core && n < 20) begin tick(); n++; end
      check_val("stuck_at_rise", int'(stuck_low), EXP_STUCK_HI);
      tick();
      check_val("stuck_cleared", int'(stuck_low), 0);
      repeat (5) tick();

      // Request gated by core_busy
      core_busy = 1'b1; recover_req = 1'b1;
      tick();
      recover_req = 1'b0;
      seen_low = 0;
      for (int i = 0; i < 6; i++) begin
         if (recover_busy || scl_pad_oe) seen_low = 1;
         tick();
      end
      check_val("gated_request", seen_low, 0);
      core_busy = 1'b0;

      // SDA stuck low: 9 pulses, STOP attempt, fail; core drive and core_busy ignored
      prescale = 16'd4; slave_sda_low = 1'b1; sda_release_after = 99;
      start_recovery(9, 1, -1);
      scl_t_core = 1'b0; sda_t_core = 1'b0; core_busy = 1'b1;
      wait_idle(3000);
      scl_t_core = 1'b1; sda_t_core = 1'b1; core_busy = 1'b0;
      slave_sda_low = 1'b0;
      repeat (10) tick();
      check_val("fail_sticky", int'(recover_fail), 1);

      // Early release after the 3rd pulse, with a request while busy
      prescale = 16'd5; slave_sda_low = 1'b1; sda_release_after = 3;
      start_recovery(3, 0, -1);
      repeat (30) tick();
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      wait_idle(3000);
      slave_sda_low = 1'b0;
      repeat (10) tick();

      // Clock stretch during the first high phase, release after 2 pulses
      prescale = 16'd4; slave_sda_low = 1'b1; sda_release_after = 2;
      start_recovery(2, 0, 1);
      wait_idle(3000);
      slave_sda_low = 1'b0;
      repeat (10) tick();

      // Reset mid-recovery: pads released, no done
      slave_sda_low = 1'b1; sda_release_after = 99; stretch_idx = -1;
      recover_req = 1'b1; tick(); recover_req = 1'b0;
      repeat (30) tick();
      rst_n = 1'b0; tick();
      check_val("rst_mid_busy", int'(recover_busy), 0);
      check_val("rst_mid_pads", int'({scl_pad_oe, sda_pad_oe}), 0);
      rst_n = 1'b1; slave_sda_low = 1'b0;
      repeat (40) tick();

      check_val("scoreboard_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
